// File: rtl/imem_stream_loader_if.sv
// ----------------------------------------------------------------------------
// imem_stream_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write bus of
//   the program loader.
//   slave  : loader side   (consumes bytes, drives the memory write port)
//   master : environment   (produces bytes, observes the memory write port)
//   Signals:
//     in_valid / in_data / in_ready : byte stream, accepted when valid & ready
//     imem_we / imem_addr / imem_wdata : one-cycle instruction-memory write
// ----------------------------------------------------------------------------
interface imem_stream_loader_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 19
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_stream_loader.sv
// ----------------------------------------------------------------------------
// imem_stream_loader
//   Loads a program image into the instruction memory of the 19-bit core.
//   Stream: 16-bit big-endian word count N, then N words of 3 bytes each
//   (word = {b0[2:0], b1, b2}, b0[7:3] must be zero). Word k goes to
//   address k. The core is held in reset (cpu_hold) until the load is done.
//
//   Optional build macro IMEM_LOADER_CHECKSUM_EN: after the last word one
//   trailer byte is expected that equals the XOR of all payload bytes.
//
//   Ports:
//     clk      : clock, rising edge
//     rst      : asynchronous reset, active low
//     start    : pulse, re-arms the loader from DONE or ERR
//     bus      : imem_stream_loader_if.slave (byte stream + imem write port)
//     cpu_hold : 1 = keep the core in reset
//     done     : load completed (level)
//     error    : load aborted (level)
// ----------------------------------------------------------------------------
module imem_stream_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 19
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_stream_loader_if.slave bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [3:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WR,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        n_q;
    logic [ADDR_W:0]    idx_q;      // one extra bit so N = 2**ADDR_W is reachable
    logic [2:0]         b0_q;
    logic [7:0]         b1_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               accept;
    logic               restart;
    logic [15:0]        n_full;
    logic               last_word;
    // After the last word (or an empty image) the next step is DONE, or the
    // checksum trailer when that feature is built in.
    state_t             end_state;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
    assign end_state = S_CHK;
`else
    assign end_state = S_DONE;
`endif

    assign accept    = bus.in_valid && bus.in_ready;
    assign restart   = start && (state_q == S_DONE || state_q == S_ERR);
    assign n_full    = {n_q[15:8], bus.in_data};
    assign last_word = (17'(idx_q) + 17'd1) == {1'b0, n_q};

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_HDR_HI;
        else      state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_HI: if (accept) state_d = S_HDR_LO;
            S_HDR_LO: if (accept) begin
                if (n_full == 16'd0)                state_d = end_state;
                else if ({1'b0, n_full} > DEPTH)    state_d = S_ERR;
                else                                state_d = S_B0;
            end
            S_B0:     if (accept) state_d = (bus.in_data[7:3] != 5'd0) ? S_ERR : S_B1;
            S_B1:     if (accept) state_d = S_B2;
            S_B2:     if (accept) state_d = S_WR;
            S_WR:     state_d = last_word ? end_state : S_B0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:    if (accept) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
`endif
            S_DONE:   if (start) state_d = S_HDR_HI;
            S_ERR:    if (start) state_d = S_HDR_HI;
            default:  state_d = S_HDR_HI;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.in_ready = 1'b0;
        bus.imem_we  = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (state_q)
            S_HDR_HI, S_HDR_LO, S_B0, S_B1, S_B2: bus.in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:  bus.in_ready = 1'b1;
`endif
            S_WR:   bus.imem_we  = 1'b1;
            S_DONE: begin cpu_hold = 1'b0; done = 1'b1; end
            S_ERR:  error        = 1'b1;
            default: ;
        endcase
        // Reset state is HDR_HI; keep the stream stalled while reset is held.
        if (!rst) bus.in_ready = 1'b0;
    end

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // ---------------- datapath ----------------
    // Address and data are captured with the third byte so they are stable
    // during WR and simply hold afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q     <= '0;
            idx_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (restart) begin
            n_q     <= '0;
            idx_q   <= '0;
        end else begin
            if (accept) begin
                case (state_q)
                    S_HDR_HI: n_q[15:8] <= bus.in_data;
                    S_HDR_LO: n_q[7:0]  <= bus.in_data;
                    S_B0:     b0_q      <= bus.in_data[2:0];
                    S_B1:     b1_q      <= bus.in_data;
                    S_B2: begin
                        addr_q  <= idx_q[ADDR_W-1:0];
                        wdata_q <= {b0_q, b1_q, bus.in_data};
                    end
                    default: ;
                endcase
            end
            if (state_q == S_WR) idx_q <= idx_q + 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         csum_q <= '0;
        else if (restart) csum_q <= '0;
        else if (accept && (state_q == S_B0 || state_q == S_B1 || state_q == S_B2))
            csum_q <= csum_q ^ bus.in_data;
    end
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_stream_loader
//   Drives byte streams (directed and $urandom) into imem_stream_loader and
//   compares the memory writes and final status against a stream-level model
//   of the image format. Honours IMEM_LOADER_CHECKSUM_EN like the design.
// ----------------------------------------------------------------------------
module tb_imem_stream_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk, rst, start;
    logic cpu_hold, done, error;

    imem_stream_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(19)) bus ();

    imem_stream_loader #(.ADDR_W(ADDR_W), .INSTR_W(19)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  stim_q[$];
    int          exp_addr_q[$];
    logic [18:0] exp_data_q[$];
    logic        exp_done, exp_err;
    logic [18:0] last_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: interpret stim_q according to the image format.
    task automatic build_model();
        int n, p;
        logic [7:0] x;
        x = 8'h00;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'({stim_q[0], stim_q[1]});
        if (n > DEPTH) begin exp_err = 1'b1; return; end
        for (int k = 0; k < n; k++) begin
            p = 2 + 3 * k;
            if (stim_q[p] > 8'd7) begin exp_err = 1'b1; return; end
            exp_addr_q.push_back(k);
            exp_data_q.push_back(stim_q[p] * 19'h10000 + stim_q[p+1] * 19'h100 + 19'(stim_q[p+2]));
            x = x ^ stim_q[p] ^ stim_q[p+1] ^ stim_q[p+2];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (stim_q[2 + 3 * n] != x) begin exp_err = 1'b1; return; end
`endif
        exp_done = 1'b1;
    endtask

    task automatic gen_stream(input int n, input int bad_k, input bit bad_sum);
        logic [7:0] b, x;
        x = 8'h00;
        stim_q.delete();
        stim_q.push_back(8'(n >> 8));
        stim_q.push_back(8'(n));
        if (n > DEPTH) begin
            repeat (3) stim_q.push_back(8'($urandom_range(0, 7)));
            return;
        end
        for (int k = 0; k < n; k++) begin
            b = (k == bad_k) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            stim_q.push_back(b); x ^= b;
            b = 8'($urandom_range(0, 255)); stim_q.push_back(b); x ^= b;
            b = 8'($urandom_range(0, 255)); stim_q.push_back(b); x ^= b;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q.push_back(bad_sum ? (x ^ 8'($urandom_range(1, 255))) : x);
`else
        if (bad_sum) stim_q.push_back(8'($urandom_range(0, 255)));
`endif
    endtask

    // Streams stim_q, checks every write and the final status. abort_wr > 0
    // pulls reset after that many writes and returns without final checks.
    task automatic run_stream(input int gap_pct, input bit chk_rate, input int abort_wr);
        int idx, cyc, nwr, last_wr, settle;
        idx = 0; cyc = 0; nwr = 0; last_wr = -1; settle = 0;
        build_model();
        @(negedge clk);
        while (settle < 4 && cyc < 5000) begin
            if (bus.imem_we) begin
                chk("wr_rdy", 32'(bus.in_ready), 32'd0);
                if (nwr < exp_addr_q.size()) begin
                    chk("wr_addr", 32'(bus.imem_addr), 32'(exp_addr_q[nwr]));
                    chk("wr_data", 32'(bus.imem_wdata), 32'(exp_data_q[nwr]));
                end
                if (chk_rate && last_wr >= 0) chk("wr_gap", 32'(cyc - last_wr), 32'd4);
                last_wr    = cyc;
                last_wdata = bus.imem_wdata;
                nwr++;
                if (abort_wr > 0 && nwr == abort_wr) begin
                    rst = 1'b0;
                    bus.in_valid = 1'b0;
                    #1;
                    chk("rst_rdy",   32'(bus.in_ready),   32'd0);
                    chk("rst_we",    32'(bus.imem_we),    32'd0);
                    chk("rst_addr",  32'(bus.imem_addr),  32'd0);
                    chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
                    chk("rst_hold",  32'(cpu_hold),       32'd1);
                    chk("rst_done",  32'(done),           32'd0);
                    chk("rst_err",   32'(error),          32'd0);
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("rel_rdy",  32'(bus.in_ready), 32'd1);
                    chk("rel_hold", 32'(cpu_hold),     32'd1);
                    return;
                end
            end
            if (done || error) settle++;
            if (idx < stim_q.size() && $urandom_range(0, 99) >= gap_pct) begin
                bus.in_valid = 1'b1;
                bus.in_data  = stim_q[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (cyc >= 5000) chk("timeout", 32'(cyc), 32'd0);
        chk("wr_cnt", 32'(nwr), 32'(exp_addr_q.size()));
        chk("done",   32'(done),     32'(exp_done));
        chk("error",  32'(error),    32'(exp_err));
        chk("hold",   32'(cpu_hold), 32'(!exp_done));
        chk("term_rdy", 32'(bus.in_ready), 32'd0);
    endtask

    // start together with a valid byte: start wins, the byte is dropped.
    task automatic pulse_start();
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        chk("st_done", 32'(done),         32'd0);
        chk("st_err",  32'(error),        32'd0);
        chk("st_hold", 32'(cpu_hold),     32'd1);
        chk("st_rdy",  32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("r_rdy",   32'(bus.in_ready),   32'd0);
        chk("r_we",    32'(bus.imem_we),    32'd0);
        chk("r_addr",  32'(bus.imem_addr),  32'd0);
        chk("r_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("r_hold",  32'(cpu_hold),       32'd1);
        chk("r_done",  32'(done),           32'd0);
        chk("r_err",   32'(error),          32'd0);
        rst = 1'b1;

        // single word 5A53C
        stim_q = '{8'h00, 8'h01, 8'h05, 8'hA5, 8'h3C};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q.push_back(8'h9C);
`endif
        run_stream(0, 1'b0, 0);
        chk("tp1_data", 32'(last_wdata), 32'h5A53C);
        chk("tp1_done", 32'(done), 32'd1);
        pulse_start();

        // three words, sustained rate
        stim_q = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF, 8'h01, 8'h23, 8'h45};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q.push_back(8'h00 ^ 8'h00 ^ 8'h01 ^ 8'h07 ^ 8'hFF ^ 8'hFF ^ 8'h01 ^ 8'h23 ^ 8'h45);
`endif
        run_stream(0, 1'b1, 0);
        pulse_start();

        // empty image
        stim_q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q.push_back(8'h00);
`endif
        run_stream(0, 1'b0, 0);
        pulse_start();

        // N = 257 too large
        gen_stream(257, -1, 1'b0);
        run_stream(0, 1'b0, 0);
        chk("big_err", 32'(error), 32'd1);
        pulse_start();

        // N = 256 fills memory exactly
        gen_stream(DEPTH, -1, 1'b0);
        run_stream(0, 1'b1, 0);
        chk("full_last", 32'(bus.imem_addr), 32'(DEPTH - 1));
        pulse_start();

        // bad first byte (0x08) in second word
        stim_q = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h08, 8'h00, 8'h00};
        run_stream(0, 1'b0, 0);
        pulse_start();

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q = '{8'h00, 8'h01, 8'h05, 8'hA5, 8'h3C, 8'h00};
        run_stream(0, 1'b0, 0);
        chk("csum_err", 32'(error), 32'd1);
        pulse_start();
`endif

        // reset after word 1 of 3, then a fresh load from address 0
        gen_stream(3, -1, 1'b0);
        run_stream(0, 1'b0, 1);
        gen_stream(3, -1, 1'b0);
        run_stream(20, 1'b0, 0);
        pulse_start();

        // randomized images with random stalls and faults
        for (int t = 0; t < 24; t++) begin
            gen_stream($urandom_range(1, 8),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1,
                       $urandom_range(0, 4) == 0);
            run_stream(30, 1'b0, 0);
            pulse_start();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
